// File: rtl/flp32_ctrl_pkg.sv
// Shared constants and the s1 pipeline entry type for the shared FP32 add/sub datapath.
package flp32_ctrl_pkg;

  localparam int FLP_W    = 32;
  localparam int MAX_ID_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // id is sized for the largest supported requester count; the top truncates to ID_W
  typedef struct packed {
    logic [FLP_W-1:0]    a;
    logic [FLP_W-1:0]    b;
    logic                op;
    logic [MAX_ID_W-1:0] id;
  } s1_entry_t;

endpackage

// File: rtl/flp32_add_sub.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
module flp32_add_sub
  import flp32_ctrl_pkg::*;
(
  input  logic [FLP_W-1:0] a,
  input  logic [FLP_W-1:0] b,
  output logic [FLP_W-1:0] result_add,
  output logic [FLP_W-1:0] result_sub
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y,
                                         input logic sub);
    logic [31:0] yy, big, sml, res;
    logic        s_big, s_sml, eff_sub, up;
    logic        x_nan, y_nan, x_inf, y_inf;
    logic [8:0]  e_big, e_sml, d, e, e_out;
    logic [26:0] m_big, m_sml, m_sh, diff, m_n, mask;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [24:0] rnd;
    logic [22:0] frac;

    res  = '0;  big  = '0;  sml   = '0;  e    = '0;  e_out = '0;
    m_sh = '0;  diff = '0;  m_n   = '0;  mask = '0;  sum   = '0;
    lz   = '0;  sh   = '0;  rnd   = '0;  frac = '0;  up    = 1'b0;

    yy    = {y[31] ^ sub, y[30:0]};
    x_nan = (&x[30:23]) && (|x[22:0]);
    y_nan = (&y[30:23]) && (|y[22:0]);
    x_inf = (&x[30:23]) && !(|x[22:0]);
    y_inf = (&y[30:23]) && !(|y[22:0]);

    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != yy[31]))) begin
      res = 32'h7FC0_0000;
    end else if (x_inf) begin
      res = x;
    end else if (y_inf) begin
      res = yy;
    end else begin
      // Low 31 bits of IEEE floats order by magnitude, so one compare picks the larger operand
      if (x[30:0] >= yy[30:0]) begin
        big = x;  sml = yy;
      end else begin
        big = yy; sml = x;
      end
      s_big   = big[31];
      s_sml   = sml[31];
      eff_sub = s_big ^ s_sml;
      e_big   = (big[30:23] == 8'd0) ? 9'd1 : {1'b0, big[30:23]};
      e_sml   = (sml[30:23] == 8'd0) ? 9'd1 : {1'b0, sml[30:23]};
      m_big   = {|big[30:23], big[22:0], 3'b000};
      m_sml   = {|sml[30:23], sml[22:0], 3'b000};
      d       = e_big - e_sml;

      if (d >= 9'd27) begin
        m_sh[0] = |m_sml;
      end else begin
        mask    = ~({27{1'b1}} << d);
        m_sh    = m_sml >> d;
        m_sh[0] = m_sh[0] | (|(m_sml & mask));
      end

      if (!eff_sub) begin
        sum = {1'b0, m_big} + {1'b0, m_sh};
        if (sum[27]) begin
          m_n = {sum[27:2], sum[1] | sum[0]};
          e   = e_big + 9'd1;
        end else begin
          m_n = sum[26:0];
          e   = e_big;
        end
      end else begin
        diff = m_big - m_sh;
        lz   = lzc27(diff);
        // Normalisation stops at exponent 1 so tiny results land as denormals
        sh   = ({4'b0, lz} < e_big) ? lz : (e_big[4:0] - 5'd1);
        m_n  = diff << sh;
        e    = e_big - {4'b0, sh};
      end

      if (eff_sub && (diff == 27'd0)) begin
        res = {s_big & s_sml, 31'd0};
      end else begin
        up  = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        rnd = {1'b0, m_n[26:3]} + {24'd0, up};
        if (rnd[24]) begin
          e_out = e + 9'd1;
          frac  = rnd[23:1];
        end else begin
          e_out = rnd[23] ? e : 9'd0;
          frac  = rnd[22:0];
        end
        if (e_out >= 9'd255) res = {s_big, 8'hFF, 23'd0};
        else                 res = {s_big, e_out[7:0], frac};
      end
    end
    return res;
  endfunction

  assign result_add = fp_add(a, b, 1'b0);
  assign result_sub = fp_add(a, b, 1'b1);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester found scanning from ptr upwards, modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  localparam int unsigned N = NUM_REQ;

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !grant_valid && req[ID_W'(idx)]) begin
        grant[ID_W'(idx)] = 1'b1;
        grant_idx         = ID_W'(idx);
        grant_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flp32_addsub_arbiter.sv
// Round-robin shared FP32 add/sub: NUM_REQ valid/ready requesters, 2-stage pipeline, id-tagged response.
module flp32_addsub_arbiter
  import flp32_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [FLP_W*NUM_REQ-1:0] req_a,
  input  logic [FLP_W*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FLP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  logic               s1_valid, s2_valid;
  logic               s1_adv, s2_adv;
  s1_entry_t          s1_q;
  logic [ID_W-1:0]    rr_ptr, rr_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    g_idx;
  logic               accept;
  logic [FLP_W-1:0]   sel_a, sel_b;
  logic               sel_op;
  logic [FLP_W-1:0]   result_add, result_sub, s2_d;

  assign s2_adv = !s2_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // rst_n in the enable keeps req_ready low for the whole reset window
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .en          (s1_adv && rst_n),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (g_idx),
    .grant_valid (accept)
  );

  assign req_ready = grant;
  assign rr_next   = (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*FLP_W +: FLP_W];
        sel_b  = req_b[i*FLP_W +: FLP_W];
        sel_op = req_op[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      rr_ptr   <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_q   <= '{a: sel_a, b: sel_b, op: sel_op, id: MAX_ID_W'(g_idx)};
        rr_ptr <= rr_next;
      end
    end
  end

  flp32_add_sub u_fp (
    .a          (s1_q.a),
    .b          (s1_q.b),
    .result_add (result_add),
    .result_sub (result_sub)
  );

  assign s2_d = (s1_q.op == OP_SUB) ? result_sub : result_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= s2_d;
        rsp_id   <= ID_W'(s1_q.id);
      end
    end
  end

  assign rsp_valid = s2_valid;

endmodule
